shift_sequencer: RTL
====================

# shift_sequencer

Control stage placed directly upstream of the 8-bit load/shift register. It accepts one byte with a shift amount and a logical/arithmetic select on a start pulse. It then drives the register's parallel-load, shift-right and arithmetic-fill controls for exactly the requested number of cycles, and raises a one-cycle done pulse. The shift-register datapath stays a pure slave, and callers get a single-transaction interface.

## Interface
- DATA_W, 8, width of loaded byte and load_val output
- CNT_W, 3, width of shift amount; legal amounts 0 .. 2^CNT_W-1
- clk  input  1  rising-edge clock, shared with the shift register
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- data_in  input  DATA_W  byte to load
- amount  input  CNT_W  number of right shifts to apply
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill)
- load_val  output  DATA_W  registered copy of data_in, to the register's LoadVal
- load_n  output  1  active-low parallel load to the register
- shift_right  output  1  shift enable to the register
- asr  output  1  arithmetic fill select to the register
- busy  output  1  high in LOAD and SHIFT
- done  output  1  one-cycle completion pulse

## Operation
- The FSM has four states: IDLE, LOAD, SHIFT and DONE. State and all outputs are registered. Outputs are decoded from the state and latched fields only, with no combinational path from the inputs.
- IDLE
  - Outputs: load_n=1, shift_right=0, asr=0, busy=0, done=0.
  - start=1 captures data_in into load_val, amount into cnt, and arith into arith_q, then moves to LOAD.
- LOAD
  - Outputs: load_n=0, shift_right=0, busy=1.
  - Next state is DONE if cnt==0, otherwise SHIFT.
- SHIFT
  - Outputs: load_n=1, shift_right=1, asr=arith_q, busy=1.
  - cnt decrements by 1 every cycle.
  - When cnt==1 on the clock edge, next state is DONE.
- DONE
  - Outputs: done=1, busy=0, load_n=1, shift_right=0, asr=0.
  - Unconditional return to IDLE. start is ignored in DONE.
- start while busy is ignored, with no queuing. data_in, amount and arith may change freely after capture.
- cnt is an unsigned CNT_W-bit value and never wraps. The path with amount==0 bypasses SHIFT.
- load_val holds the last captured byte until the next capture.

## Timing
- Reset: state=IDLE, cnt=0, arith_q=0, load_val=0, load_n=1, shift_right=0, asr=0, busy=0, done=0. Reset takes effect immediately, not at a clock edge.
- Reset mid-operation abandons the transaction: no done pulse, and the outputs go to their reset values at once.
- start is sampled at edge E0. LOAD is active in the cycle after E0, and the register loads at edge E1.
- N shift cycles follow. The register performs shifts at edges E2 .. E(N+1).
- done is high during cycle N+2 after E0. A new start is accepted at the earliest at edge E(N+3).
- Throughput: one transaction per N+3 cycles.

## Configuration
- SHIFT_SEQUENCER_ABORT_EN: when defined, adds input port abort (1 bit).
  - abort=1 in LOAD or SHIFT forces next state DONE: done pulses, remaining shifts are skipped, and the register keeps its partial result.
  - abort in IDLE or DONE is ignored.
  - start and abort together in IDLE: start is taken.
- When the macro is undefined, the port does not exist and every transaction runs to completion.

## Test plan
- Reset asserted for 2 cycles then released → every output is at its reset value; no done pulse appears for 10 idle cycles.
- data_in=8'hB4, amount=3, arith=0, start pulse:
  - load_n is low for exactly 1 cycle, then shift_right is high for 3 cycles, then done pulses 1 cycle.
  - The attached register reads 8'h16.
- Same with arith=1:
  - asr is high during the 3 shift cycles.
  - The register reads 8'hF6.
  - start-to-done latency is 5 cycles.
- amount=0, data_in=8'h5A, start:
  - LOAD is followed directly by done at cycle 2, with no shift_right.
  - The register reads 8'h5A.
- start held high for the whole of an amount=7 run:
  - The second capture occurs only after DONE, at cycle 10.
  - Exactly 7 shift cycles occur per transaction.
- Reset asserted during the 2nd SHIFT cycle → outputs return to reset values asynchronously and done never pulses. With SHIFT_SEQUENCER_ABORT_EN defined, abort in that cycle instead gives done on the next cycle after 2 shifts.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Caller-facing bus of the shift sequencer: request fields in, shift-register controls out.
// The abort input exists only when SHIFT_SEQUENCER_ABORT_EN is defined.
interface shift_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 3
);
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic [CNT_W-1:0]  amount;
  logic              arith;
`ifdef SHIFT_SEQUENCER_ABORT_EN
  logic              abort;
`endif
  logic [DATA_W-1:0] load_val;
  logic              load_n;
  logic              shift_right;
  logic              asr;
  logic              busy;
  logic              done;

`ifdef SHIFT_SEQUENCER_ABORT_EN
  modport master (
    output start, data_in, amount, arith, abort,
    input  load_val, load_n, shift_right, asr, busy, done
  );
  modport slave (
    input  start, data_in, amount, arith, abort,
    output load_val, load_n, shift_right, asr, busy, done
  );
`else
  modport master (
    output start, data_in, amount, arith,
    input  load_val, load_n, shift_right, asr, busy, done
  );
  modport slave (
    input  start, data_in, amount, arith,
    output load_val, load_n, shift_right, asr, busy, done
  );
`endif
endinterface

// File: rtl/shift_sequencer.sv
// Sequences load / N right-shifts / done for a slave 8-bit shift register.
// Optional SHIFT_SEQUENCER_ABORT_EN adds an abort input that cuts a transaction short.
module shift_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt;
  logic              arith_q;
  logic [DATA_W-1:0] load_val_q;
  logic              abort_c;

  logic load_n_d, shift_right_d, asr_d, busy_d, done_d;
  logic load_n_q, shift_right_q, asr_q, busy_q, done_q;

`ifdef SHIFT_SEQUENCER_ABORT_EN
  assign abort_c = bus.abort;
`else
  assign abort_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic; cnt <= 1 exit keeps the counter from ever wrapping
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    state_d = (abort_c || cnt == '0) ? DONE : SHIFT;
      SHIFT:   if (abort_c || cnt <= CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and shift countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_val_q <= '0;
      cnt        <= '0;
      arith_q    <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      load_val_q <= bus.data_in;
      cnt        <= bus.amount;
      arith_q    <= bus.arith;
    end else if (state == SHIFT && cnt != '0) begin
      cnt        <= cnt - CNT_W'(1);
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    load_n_d      = 1'b1;
    shift_right_d = 1'b0;
    asr_d         = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    case (state_d)
      LOAD: begin
        load_n_d = 1'b0;
        busy_d   = 1'b1;
      end
      SHIFT: begin
        shift_right_d = 1'b1;
        asr_d         = arith_q;
        busy_d        = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_n_q      <= 1'b1;
      shift_right_q <= 1'b0;
      asr_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      load_n_q      <= load_n_d;
      shift_right_q <= shift_right_d;
      asr_q         <= asr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.load_val    = load_val_q;
  assign bus.load_n      = load_n_q;
  assign bus.shift_right = shift_right_q;
  assign bus.asr         = asr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
